note_sequencer: RTL and testbench

- Plays a short song from an internal programmable pattern table.
- Each table entry holds a note number and a duration in beats.
- Drives the 27-bit note bus consumed directly by note_decoder_full; zero on the bus means silence.
- Sits between the top-level control (buttons/host load port) and the note decoder.

---
 rtl/note_sequencer.sv | 147 ++++++++++++++
 tb/tb_note_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Pattern-table note sequencer: plays {note, beats} entries onto the note bus.
// Optional NOTE_SEQ_GAP_EN inserts GAP_TICKS silent cycles after every entry.
module note_sequencer #(
    parameter int DEPTH          = 16,
    parameter int TICKS_PER_BEAT = 1000,
    parameter int NOTE_W         = 27,
    parameter int GAP_TICKS      = 8,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [6:0]        load_note,
    input  logic [3:0]        load_len,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    output logic [AW-1:0]     step,
    output logic              busy,
    output logic              done
);
    localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TICKS_PER_BEAT - 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] PLAY  = 2'd2;

    if (TICKS_PER_BEAT < 1 || GAP_TICKS < 1) begin : g_param_chk
        $error("note_sequencer: TICKS_PER_BEAT and GAP_TICKS must be >= 1");
    end

    logic [1:0]    state;
    logic [10:0]   tbl [DEPTH];
    logic [10:0]   ent;
    logic [TW-1:0] tick;
    logic [3:0]    beat;
    logic          play_last;
    logic          adv;

    assign ent       = tbl[step];
    assign busy      = (state != IDLE);
    assign play_last = (state == PLAY) && (tick == TMAX) && (beat == 4'd1);

`ifdef NOTE_SEQ_GAP_EN
    localparam logic [1:0] GAP = 2'd3;
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam logic [GW-1:0] GMAX = GW'(GAP_TICKS - 1);
    logic [GW-1:0] gcnt;
    assign adv = (state == GAP) && (gcnt == GMAX);
`else
    assign adv = play_last;
`endif

    // Table has no reset; it only accepts writes while idle.
    always_ff @(posedge clk) begin
        if (load_we && state == IDLE)
            tbl[load_addr] <= {load_len, load_note};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            note       <= '0;
            note_valid <= 1'b0;
            step       <= '0;
            done       <= 1'b0;
            tick       <= '0;
            beat       <= '0;
`ifdef NOTE_SEQ_GAP_EN
            gcnt       <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (stop) begin
                state      <= IDLE;
                note       <= '0;
                note_valid <= 1'b0;
                step       <= '0;
                tick       <= '0;
                beat       <= '0;
            end else if (adv) begin
                // Entry finished: last slot either ends the song or wraps.
                if (step == LAST && !loop_en) begin
                    state      <= IDLE;
                    note       <= '0;
                    note_valid <= 1'b0;
                    done       <= 1'b1;
                    step       <= '0;
                end else begin
                    step  <= step + 1'b1;
                    state <= FETCH;
                end
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state <= FETCH;
                        step  <= '0;
                    end
                    FETCH: begin
                        if (ent[10:7] == 4'd0) begin
                            if (loop_en) begin
                                step <= '0;
                            end else begin
                                state      <= IDLE;
                                note       <= '0;
                                note_valid <= 1'b0;
                                done       <= 1'b1;
                                step       <= '0;
                            end
                        end else begin
                            note       <= NOTE_W'(ent[6:0]);
                            note_valid <= |ent[6:0];
                            beat       <= ent[10:7];
                            tick       <= '0;
                            state      <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick == TMAX) begin
                            tick <= '0;
                            beat <= beat - 1'b1;
                        end else begin
                            tick <= tick + 1'b1;
                        end
`ifdef NOTE_SEQ_GAP_EN
                        if (play_last) begin
                            state      <= GAP;
                            gcnt       <= '0;
                            note       <= '0;
                            note_valid <= 1'b0;
                        end
`endif
                    end
`ifdef NOTE_SEQ_GAP_EN
                    GAP: gcnt <= gcnt + 1'b1;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a song-level model expands the table into a per-cycle trace.
module tb_note_sequencer;
    localparam int DEPTH = 16, TPB = 4, NW = 27, GAPT = 2, AW = 4;
`ifdef NOTE_SEQ_GAP_EN
    localparam int GAPM = GAPT;
`else
    localparam int GAPM = 0;
`endif

    logic          clk = 0, rst_n = 0, start = 0, stop = 0, loop_en = 0, load_we = 0;
    logic [AW-1:0] load_addr = '0;
    logic [6:0]    load_note = '0;
    logic [3:0]    load_len = '0;
    logic [NW-1:0] note;
    logic          note_valid, busy, done;
    logic [AW-1:0] step;

    note_sequencer #(.DEPTH(DEPTH), .TICKS_PER_BEAT(TPB), .NOTE_W(NW), .GAP_TICKS(GAPT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .load_we(load_we), .load_addr(load_addr), .load_note(load_note), .load_len(load_len),
        .note(note), .note_valid(note_valid), .step(step), .busy(busy), .done(done));

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] note;
        logic          nv;
        int            step;
        logic          busy;
        logic          done;
    } obs_t;

    obs_t       exp_q[$];
    logic [6:0] m_note [DEPTH];
    logic [3:0] m_len  [DEPTH];
    int         npass = 0, nchk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic void push(logic [6:0] n, logic nv, int s, logic b, logic d);
        obs_t o;
        o.note = NW'(n); o.nv = nv; o.step = s; o.busy = b; o.done = d;
        exp_q.push_back(o);
    endfunction

    // Walk the song entry by entry; the note bus holds its old value during a fetch.
    task automatic build(input bit lp, input int maxc);
        int s = 0;
        logic [6:0] prev = 0;
        bit fin = 0;
        exp_q.delete();
        while (exp_q.size() < maxc && !fin) begin
            push(prev, prev != 0, s, 1, 0);
            if (m_len[s] == 0) begin
                if (lp) s = 0;
                else fin = 1;
            end else begin
                repeat (int'(m_len[s]) * TPB) push(m_note[s], m_note[s] != 0, s, 1, 0);
                prev = m_note[s];
                if (GAPM > 0) begin
                    repeat (GAPM) push(0, 0, s, 1, 0);
                    prev = 0;
                end
                if (s == DEPTH - 1 && !lp) fin = 1;
                else s = (s + 1) % DEPTH;
            end
        end
        if (fin) begin
            push(0, 0, 0, 0, 1);
            push(0, 0, 0, 0, 0);
            push(0, 0, 0, 0, 0);
        end
        while (exp_q.size() > maxc) void'(exp_q.pop_back());
    endtask

    task automatic load(input int a, input int n, input int l, input bit upd);
        load_we = 1; load_addr = AW'(a); load_note = 7'(n); load_len = 4'(l);
        tick();
        load_we = 0;
        if (upd) begin m_note[a] = 7'(n); m_len[a] = 4'(l); end
    endtask

    // poke: trace index before whose edge start is re-pulsed while busy (-1 = none).
    task automatic play(input string tag, input bit lp, input int maxc, input int poke);
        build(lp, maxc);
        loop_en = lp;
        start = 1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                start = (i == poke) && exp_q[i-1].busy;
                tick();
            end else begin
                tick();
                start = 0;
            end
            chk(tag, {note, note_valid, busy, done},
                {exp_q[i].note, exp_q[i].nv, exp_q[i].busy, exp_q[i].done});
            if (exp_q[i].busy) chk({tag, "_step"}, 64'(step), 64'(exp_q[i].step));
        end
        start = 0;
    endtask

    task automatic do_stop(input string tag);
        stop = 1; tick(); stop = 0;
        chk(tag, {note, note_valid, step, busy, done}, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin m_note[i] = 0; m_len[i] = 0; end
        #12;
        chk("reset", {note, note_valid, step, busy, done}, 0);
        @(negedge clk); rst_n = 1;
        tick();
        for (int i = 0; i < DEPTH; i++) load(i, 0, 0, 1);

        // basic song, then looped
        load(0, 61, 1, 1); load(1, 62, 2, 1); load(2, 0, 0, 1);
        play("song", 0, 40, -1);
        play("loop", 1, 30, 3);
        do_stop("loop_stop");

        // stop mid-note, with a dropped table write during playback
        play("pre_stop", 0, 8, -1);
        load(0, 99, 3, 0);
        do_stop("stop");
        play("replay", 0, 40, -1);

        // rest entry
        load(1, 0, 2, 1); load(2, 63, 1, 1); load(3, 0, 0, 1);
        play("rest", 0, 40, -1);

        // full table without end marker
        for (int i = 0; i < DEPTH; i++) load(i, 64 + i, 1, 1);
        play("full", 0, 200, -1);

        // repeated note for gap articulation
        load(0, 70, 1, 1); load(1, 70, 1, 1); load(2, 0, 0, 1);
        play("repeat", 0, 30, -1);

        // empty looping song spins until stopped
        load(0, 0, 0, 1);
        play("empty", 1, 10, -1);
        do_stop("empty_stop");

        // asynchronous reset mid-playback
        load(0, 61, 1, 1); load(1, 62, 2, 1);
        play("pre_rst", 1, 6, -1);
        #2 rst_n = 0;
        #1 chk("async_rst", {note, note_valid, step, busy, done}, 0);
        @(negedge clk); rst_n = 1;

        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < DEPTH; i++)
                load(i, ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127),
                     ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3), 1);
            play("rand", 1'($urandom_range(0, 1)), 250, $urandom_range(2, 40));
            do_stop("rand_stop");
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
